// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the multiplier FSM
// state encodings.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage : alu_pkg

// File: rtl/adder_8_bit.sv
// Ripple-carry adder, WIDTH-parameterised. Shared between the single-cycle
// add/sub path and the sequential multiplier.
module adder_8_bit #(
    parameter int WIDTH = alu_pkg::WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);

    // Bit-serial carry chain from LSB to MSB.
    always_comb begin : ripple
        logic carry;
        carry = cin_i;
        s_o   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        co_o = carry;
    end

endmodule : adder_8_bit

// File: rtl/mult_seq_8_bit.sv
// Sequential shift-and-add unsigned multiplier. One shared adder is used
// once per cycle for WIDTH cycles; the product is held in P until the next
// completion.
//
// Handshake: start is sampled only while idle (busy low). A sampled start
// latches A and B; busy stays high through the RUN and DONE states and any
// start seen meanwhile is ignored. done pulses for exactly one cycle, and
// from that cycle on P carries the product.
module mult_seq_8_bit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_s;
    logic               add_co;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;

    // Partial product for this iteration: add the multiplicand only when the
    // current multiplier LSB (acc_lo[0]) is set.
    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    adder_8_bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i   (acc_hi_q),
        .b_i   (add_b),
        .cin_i (1'b0),
        .s_o   (add_s),
        .co_o  (add_co)
    );

    // Carry-out becomes the new accumulator MSB; the consumed multiplier
    // bit falls off the bottom.
    assign acc_next  = {add_co, add_s, acc_lo_q[WIDTH-1:1]};
    assign last_iter = (cnt_q == CNT_LAST);

    // State register; reset wins over every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed WIDTH iterations, one DONE cycle, back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the registered result.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = done_q;
        P    = p_q;
    end

    // Datapath next values: operand latch on accept, one shift-add per RUN cycle.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        p_d      = p_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = A;
                    acc_lo_d = B;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                {acc_hi_d, acc_lo_d} = acc_next;
                cnt_d                = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    p_d    = acc_next;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial result and clears P.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            p_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

endmodule : mult_seq_8_bit

// File: tb/tb_mult_seq_8_bit.sv
// Bench for mult_seq_8_bit: directed operand pairs with hand-computed
// products, a scoreboard queue of expected products and completion cycles,
// and a monitor that checks every done pulse against the queue.
module tb_mult_seq_8_bit;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int cyc;
    int n_cmp;
    int n_fail;

    logic [2*W-1:0] exp_q[$];
    int             exp_cyc_q[$];

    mult_seq_8_bit #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .P     (p)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Driver: one-cycle start pulse. When push is set, the expected product
    // and the cycle in which done must be seen go onto the scoreboard.
    // At this negedge cyc=n; accept edge makes cyc=n+1; done visible after
    // 8 more edges, i.e. at the negedge where cyc=n+1+W.
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [2*W-1:0] prod, input bit push);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(prod);
            exp_cyc_q.push_back(cyc + 1 + W);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait until done is seen at a negedge.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: done timeout, got none expected pulse", name);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse; also checks that the
    // cycle after a done pulse has done and busy both low.
    bit prev_done;
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) begin
            check("done_single_cycle", {31'd0, done}, 32'd0);
            check("busy_low_after_done", {31'd0, busy}, 32'd0);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: got P=0x%0h expected no done", p);
            end else begin
                logic [2*W-1:0] ep;
                int             ec;
                ep = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("product", {16'd0, p}, {16'd0, ep});
                check("latency", cyc, ec);
            end
        end
        prev_done = done;
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        n_cmp  = 0;
        n_fail = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_p",    {16'd0, p},    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic product, busy visible right after accept
        do_start(8'h0D, 8'h0B, 16'h008F, 1'b1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1");
        @(negedge clk);

        // 2: carry out captured every iteration
        do_start(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        wait_done("t2");
        @(negedge clk);

        // 3: zero operands still take the full latency
        do_start(8'h00, 8'hA5, 16'h0000, 1'b1);
        wait_done("t3a");
        @(negedge clk);
        do_start(8'h5A, 8'h00, 16'h0000, 1'b1);
        wait_done("t3b");
        @(negedge clk);

        // 4: starts while busy are ignored, operands not re-latched
        do_start(8'h12, 8'h34, 16'h03A8, 1'b1);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4");
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_no_restart", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        check("t4_still_idle", {31'd0, busy}, 32'd0);
        check("t4_p_held", {16'd0, p}, 32'h03A8);

        // 5: reset mid-RUN discards the operation and clears P
        do_start(8'h80, 8'h80, 16'h4000, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_p",    {16'd0, p},    32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_no_done_after_rst", {31'd0, busy}, 32'd0);
        do_start(8'h03, 8'h07, 16'h0015, 1'b1);
        wait_done("t5");
        @(negedge clk);

        // 6: back-to-back start in the first IDLE cycle after DONE
        do_start(8'h02, 8'h03, 16'h0006, 1'b1);
        wait_done("t6a");
        do_start(8'h10, 8'h10, 16'h0100, 1'b1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        check("t6_p_held", {16'd0, p}, 32'h0006);
        wait_done("t6b");
        repeat (3) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mult_seq_8_bit
